// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing one downstream CBus port among NUM_MASTERS requesters.
// A grant lasts a whole transaction and is released after the beat flagged last.

package cbus_pkg;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  len;
      logic        burst;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;

endpackage

module cbus_arbiter
   import cbus_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  cbus_req_t  [NUM_MASTERS-1:0] ireqs,
   output cbus_resp_t [NUM_MASTERS-1:0] iresps,
   output cbus_req_t                    oreq,
   input  cbus_resp_t                   oresp
);

   localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_MASTERS - 1);

   typedef enum logic {StIdle, StBusy} state_e;

   state_e          state_q, state_d;
   logic [IdxW-1:0] index_q, index_d;
   logic [IdxW-1:0] ptr_q, ptr_d;

   logic            found;
   logic [IdxW-1:0] pick;
   logic [IdxW-1:0] cand;

   // Explicit wrap so non-power-of-2 master counts never reach an unused index.
   function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] i);
      return (i == LastIdx) ? '0 : i + 1'b1;
   endfunction

   // First requester at or after ptr, in rotating order.
   always_comb begin
      found = 1'b0;
      pick  = ptr_q;
      cand  = ptr_q;
      for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
         if (!found && ireqs[cand].valid) begin
            found = 1'b1;
            pick  = cand;
         end
         cand = wrap_inc(cand);
      end
   end

   always_comb begin
      state_d = state_q;
      index_d = index_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               state_d = StBusy;
               index_d = pick;
            end
         end
         StBusy: begin
            if (oresp.ready && oresp.last) begin
               state_d = StIdle;
               ptr_d   = wrap_inc(index_q);
            end
         end
      endcase
   end

   // oreq depends only on registered state and ireqs, never on oresp.
   always_comb begin
      oreq   = '0;
      iresps = '0;
      if (state_q == StBusy) begin
         oreq            = ireqs[index_q];
         iresps[index_q] = oresp;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         index_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         ptr_q   <= ptr_d;
      end
   end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: directed scenarios plus random traffic, checked by a queue-based
// scoreboard fed from a transaction-level round-robin model.

module tb_cbus_arbiter;
   import cbus_pkg::*;

   localparam int N = 3;

   logic                 clk = 1'b0;
   logic                 reset;
   cbus_req_t  [N-1:0]   ireqs;
   cbus_resp_t [N-1:0]   iresps;
   cbus_req_t            oreq;
   cbus_resp_t           oresp;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int        m;
      cbus_req_t req;
   } exp_t;

   exp_t exp_q[$];
   int   grant_log[$];

   logic [N-1:0] act, done;
   int           beats;

   cbus_arbiter #(.NUM_MASTERS(N)) dut (
      .clk   (clk),
      .reset (reset),
      .ireqs (ireqs),
      .iresps(iresps),
      .oreq  (oreq),
      .oresp (oresp)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act_v, input logic [127:0] exp_v);
      tests++;
      if (act_v !== exp_v) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act_v, exp_v, $time);
      end
   endtask

   // Reference model: on each free cycle the winner is the requester nearest ptr going upward.
   initial begin : model
      int busy, owner, ptr, best, bestd, d;
      exp_t e;
      busy = 0; owner = 0; ptr = 0;
      forever begin
         @(negedge clk); #1;
         if (reset) begin
            busy = 0; ptr = 0;
            exp_q.delete();
         end else if (busy != 0) begin
            if (oresp.ready && oresp.last) begin
               busy = 0;
               ptr  = (owner + 1) % N;
            end
         end else begin
            best = -1; bestd = N;
            for (int i = 0; i < N; i++) begin
               d = (i - ptr + N) % N;
               if (ireqs[i].valid && d < bestd) begin
                  best = i; bestd = d;
               end
            end
            if (best >= 0) begin
               busy  = 1;
               owner = best;
               e.m   = best;
               e.req = ireqs[best];
               exp_q.push_back(e);
            end
         end
      end
   end

   initial begin : monitor
      logic prev_v;
      cbus_resp_t [N-1:0] er;
      prev_v = 1'b0;
      forever begin
         @(negedge clk);
         if (reset || exp_q.size() == 0) begin
            check("oreq idle", oreq, '0);
            check("iresps idle", iresps, '0);
         end else begin
            check("oreq route", oreq, exp_q[0].req);
            er = '0;
            er[exp_q[0].m] = oresp;
            check("iresps route", iresps, er);
            if (oresp.ready && oresp.last) void'(exp_q.pop_front());
         end
         if (oreq.valid && !prev_v) grant_log.push_back(int'(oreq.addr[31:28]));
         prev_v = oreq.valid;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic req(input int m, input logic [31:0] addr, input logic [3:0] len);
      cbus_req_t r;
      r          = '0;
      r.valid    = 1'b1;
      r.addr     = addr;
      r.data     = addr ^ 32'h5a5a_0000;
      r.len      = len;
      r.burst    = (len != 4'd0);
      ireqs[m]   = r;
   endtask

   task automatic drop(input int m);
      ireqs[m] = '0;
   endtask

   task automatic rsp(input logic r, input logic l, input logic [31:0] d);
      oresp.ready = r;
      oresp.last  = l;
      oresp.data  = d;
   endtask

   task automatic idle_chk(input string name);
      @(negedge clk);
      check(name, oreq.valid, 1'b0);
   endtask

   // Serve a single-beat grant that should be visible this cycle.
   task automatic expect_grant(input string name, input logic [31:0] a);
      rsp(1'b1, 1'b1, $urandom);
      @(negedge clk);
      check(name, {oreq.valid, oreq.addr}, {1'b1, a});
   endtask

   task automatic do_reset();
      step();
      reset = 1'b1;
      ireqs = '0; oresp = '0; act = '0; done = '0; beats = 0;
      step();
      step();
      reset = 1'b0;
   endtask

   // One cycle of random masters plus a random downstream responder.
   task automatic bus_cycle(input logic [N-1:0] mask, input int p_req, input int p_rdy,
                            input int max_len);
      step();
      for (int i = 0; i < N; i++) begin
         if ((!act[i] || done[i]) && mask[i] && int'($urandom_range(99)) < p_req) begin
            req(i, {4'(i), 28'($urandom)}, 4'($urandom_range(max_len)));
            act[i]  = 1'b1;
            done[i] = 1'b0;
         end else if (act[i] && done[i]) begin
            drop(i);
            act[i]  = 1'b0;
            done[i] = 1'b0;
         end
      end
      #1;
      if (oreq.valid && int'($urandom_range(99)) < p_rdy) begin
         rsp(1'b1, beats == int'(oreq.len), $urandom);
         beats = oresp.last ? 0 : beats + 1;
      end else begin
         oresp = '0;
      end
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (iresps[i].ready && iresps[i].last) done[i] = 1'b1;
      end
   endtask

   task automatic drain();
      for (int c = 0; c < 300 && act != '0; c++) bus_cycle('0, 0, 100, 0);
      check("drain all masters done", act, '0);
   endtask

   initial begin : main
      logic [N-1:0] rdy;
      reset = 1'b1;
      ireqs = '0; oresp = '0; act = '0; done = '0; beats = 0;
      @(negedge clk);
      check("reset oreq", oreq, '0);
      check("reset iresps", iresps, '0);
      step();
      reset = 1'b0;

      // Single master, single beat, then an immediate second request.
      step(); req(0, 32'h8000_0000, 4'd0); idle_chk("single arb cycle");
      step(); @(negedge clk);
      check("single grant c2", {oreq.valid, oreq.addr}, {1'b1, 32'h8000_0000});
      step(); rsp(1'b1, 1'b1, 32'hdead_beef); @(negedge clk);
      check("single valid c3", oreq.valid, 1'b1);
      check("single iresp c3", iresps[0], {1'b1, 1'b1, 32'hdead_beef});
      step(); rsp(1'b0, 1'b0, 32'h0); idle_chk("single released c4");
      step(); expect_grant("single back-to-back", 32'h8000_0000);
      step(); drop(0); rsp(1'b0, 1'b0, 32'h0);

      // Simultaneous requests and pointer rotation including wrap.
      do_reset();
      step(); req(0, 32'h0000_0100, 4'd0); req(1, 32'h1000_0100, 4'd0); idle_chk("sim arb");
      step(); expect_grant("sim m0 first", 32'h0000_0100);
      check("sim m1 waits", iresps[1].ready, 1'b0);
      step(); drop(0); rsp(1'b0, 1'b0, 32'h0); idle_chk("sim dead cycle");
      step(); expect_grant("sim m1 second", 32'h1000_0100);
      step(); drop(1); rsp(1'b0, 1'b0, 32'h0);
      req(0, 32'h0000_0200, 4'd0); req(2, 32'h2000_0200, 4'd0); idle_chk("sim arb 2");
      step(); expect_grant("ptr2 picks m2", 32'h2000_0200);
      check("m0 waits on m2", iresps[0].ready, 1'b0);
      step(); drop(2); rsp(1'b0, 1'b0, 32'h0); req(1, 32'h1000_0300, 4'd0); idle_chk("arb 3");
      step(); expect_grant("wrap picks m0", 32'h0000_0200);
      step(); drop(0); rsp(1'b0, 1'b0, 32'h0); idle_chk("arb 4");
      step(); expect_grant("then m1", 32'h1000_0300);
      step(); drop(1); rsp(1'b0, 1'b0, 32'h0);

      // Burst hold: m1 bursts 4 beats, m0 asks during beat 2.
      step(); req(1, 32'h1000_4000, 4'd3); idle_chk("burst arb");
      step(); rsp(1'b1, 1'b0, 32'h1); @(negedge clk);
      check("burst beat1", {oreq.valid, oreq.addr, oreq.len, oreq.burst},
            {1'b1, 32'h1000_4000, 4'd3, 1'b1});
      step(); rsp(1'b1, 1'b0, 32'h2); req(0, 32'h0000_4000, 4'd0); @(negedge clk);
      check("burst beat2 holds", oreq.addr, 32'h1000_4000);
      check("burst beat2 m0 waits", iresps[0].ready, 1'b0);
      step(); rsp(1'b0, 1'b0, 32'h0); @(negedge clk);
      check("burst stall holds", {oreq.valid, oreq.addr}, {1'b1, 32'h1000_4000});
      step(); rsp(1'b1, 1'b0, 32'h3); @(negedge clk);
      check("burst beat3 holds", oreq.addr, 32'h1000_4000);
      step(); rsp(1'b1, 1'b1, 32'h4); @(negedge clk);
      check("burst beat4", {oreq.addr, iresps[1].last, iresps[0].ready},
            {32'h1000_4000, 1'b1, 1'b0});
      step(); drop(1); rsp(1'b0, 1'b0, 32'h0); idle_chk("burst release");
      step(); expect_grant("m0 after burst", 32'h0000_4000);
      step(); drop(0); rsp(1'b0, 1'b0, 32'h0);

      // Reset mid-burst with ptr at 2; afterwards ptr must be back at 0.
      step(); req(1, 32'h1000_5000, 4'd0); idle_chk("pre-reset arb");
      step(); expect_grant("pre-reset m1", 32'h1000_5000);
      step(); drop(1); rsp(1'b0, 1'b0, 32'h0); req(2, 32'h2000_5000, 4'd3); idle_chk("arb m2");
      step(); rsp(1'b1, 1'b0, 32'h11); @(negedge clk);
      check("m2 burst beat1", oreq.addr, 32'h2000_5000);
      step(); rsp(1'b1, 1'b0, 32'h12); #1;
      reset = 1'b1; #1;
      check("async reset drops valid", oreq.valid, 1'b0);
      drop(2); rsp(1'b0, 1'b0, 32'h0);
      step(); reset = 1'b0;
      step(); req(1, 32'h1000_6000, 4'd0); req(2, 32'h2000_6000, 4'd0); idle_chk("post-reset arb");
      step(); expect_grant("post-reset ptr0 picks m1", 32'h1000_6000);
      step(); drop(1); rsp(1'b0, 1'b0, 32'h0); idle_chk("post-reset arb 2");
      step(); expect_grant("post-reset m2", 32'h2000_6000);
      step(); drop(2); rsp(1'b0, 1'b0, 32'h0);

      // Idle: no requests.
      for (int c = 0; c < 10; c++) begin
         step();
         @(negedge clk);
         for (int i = 0; i < N; i++) rdy[i] = iresps[i].ready;
         check("idle quiet", {oreq.valid, rdy}, '0);
      end

      // Fairness: m0 and m1 request back-to-back continuously.
      do_reset();
      grant_log.delete();
      for (int c = 0; c < 100 && grant_log.size() < 6; c++) bus_cycle(3'b011, 100, 100, 0);
      check("fair grant count", grant_log.size() >= 6, 1'b1);
      for (int k = 0; k < 6 && k < grant_log.size(); k++) check("fair alternation",
                                                                 grant_log[k], k % 2);
      drain();

      // Random traffic with bursts and stalls.
      do_reset();
      for (int c = 0; c < 800; c++) bus_cycle('1, 30, 70, 3);
      drain();
      step(); step();
      check("scoreboard empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cbus_arbiter.md
# cbus_arbiter

Round-robin arbiter that shares one downstream CBus port among `NUM_MASTERS` upstream CBus requesters, typically the instruction-side and data-side converter outputs. A winner is granted the downstream port for a whole transaction, single beat or burst, and holds it until the beat flagged `last` completes. It sits between the per-bus converters and the memory/interconnect CBus.

## Interface
Parameters:
- `NUM_MASTERS`, default 2: number of upstream requesters; must be ≥ 2.

Ports:
- `clk`  in  1: sole clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `ireqs`  in  `cbus_req_t [NUM_MASTERS-1:0]`: upstream requests.
- `iresps`  out  `cbus_resp_t [NUM_MASTERS-1:0]`: upstream responses.
- `oreq`  out  `cbus_req_t`: downstream request.
- `oresp`  in  `cbus_resp_t`: downstream response, with fields `ready`, `last` and `data`.

## Operation
- State: `busy` (1 bit), `index` (clog2(NUM_MASTERS) bits, current grant), `ptr` (same width, highest-priority candidate).
- Reset values: `busy`=0, `index`=0, `ptr`=0.
- IDLE (`busy`=0):
  - Scan masters `ptr`, `ptr`+1, … (mod NUM_MASTERS) for the first with `ireqs[i].valid`=1.
  - If one is found, next edge sets `index`=i and `busy`=1.
  - If none is found, stay IDLE.
- BUSY (`busy`=1):
  - `oreq` = `ireqs[index]`.
  - `iresps[index]` = `oresp`; every other `iresps[j]` = '0.
  - On a cycle with `oresp.ready`=1 and `oresp.last`=1: next edge sets `busy`=0 and `ptr`=(`index`+1) mod NUM_MASTERS.
  - `oresp.ready`=1 with `last`=0 is a mid-burst beat: stay BUSY, no state change.
- While IDLE, `oreq`='0 (valid=0) and all `iresps`='0.
- The arbiter never passes a response to a non-granted master, so non-granted masters see `ready`=0 and keep waiting.
- Upstream masters obey CBus rules: `valid` and all request fields stay stable from assertion until the `last` handshake.
- If the granted master drops `valid` before `last`, behaviour is undefined. The arbiter does not abort; it stays BUSY until `ready && last`.
- Simultaneous requests: the rotating `ptr` decides the winner, so each requester waits at most NUM_MASTERS−1 transactions.
- Index arithmetic wraps modulo NUM_MASTERS. For non-power-of-2 counts, explicitly wrap at NUM_MASTERS−1 → 0.
- Reset mid-transaction: all state returns to reset values immediately and asynchronously; `oreq.valid` drops in the same cycle. The downstream partial burst is abandoned; the system resets downstream concurrently.

## Timing
- Arbitration latency is 1 cycle. A request first visible in cycle N while IDLE appears on `oreq` in cycle N+1.
- Response path is combinational: `oresp` → `iresps[index]` in the same cycle. `oreq` is a mux of `ireqs` selected by registered `index`/`busy`.
- The grant is released one cycle after the final handshake. With `last` accepted in cycle M:
  - cycle M+1: IDLE, arbitration;
  - cycle M+2: next `oreq` valid.
- So there is exactly one dead cycle between back-to-back transactions.
- A burst of L beats occupies the port from grant until the L-th `ready` beat; `len` and `burst` are forwarded untouched.
- There is no combinational path from `oresp` to `oreq.valid`.

## Test plan
- Single master: master 0 issues a 1-beat read at 0x8000_0000 in cycle 1, and downstream returns `ready=last=1`, data 0xDEAD_BEEF, in cycle 3.
  - Required: `oreq` valid in cycles 2–3.
  - Required: `iresps[0].data`=0xDEAD_BEEF in cycle 3.
  - Required: `busy`=0 in cycle 4.
- Simultaneous: masters 0 and 1 both assert in cycle 1 after reset.
  - Required: master 0 is granted first and master 1 waits with `ready`=0.
  - Required: after master 0's `last`, master 1's request appears 2 cycles later and `ptr` becomes 0 afterwards.
- Fairness: both masters request continuously for 6 transactions.
  - Required: grants alternate 0, 1, 0, 1, 0, 1 with no starvation.
- Burst hold: master 1 issues a 4-beat burst, and master 0 requests during beat 2.
  - Required: `oreq` stays on master 1 through all 4 beats, including beats with `ready`=1, `last`=0.
  - Required: master 0 is granted only after beat 4.
- Reset mid-burst: assert `reset` asynchronously between edges during beat 2 of a burst.
  - Required: `oreq.valid`=0 immediately.
  - Required: after release, a new request from master 1 gets granted with `ptr`=0 semantics.
- Idle: no requests for 10 cycles.
  - Required: `oreq.valid`=0 and all `iresps.ready`=0 throughout.
